bayer_demosaic_param: RTL and testbench



---
 rtl/demosaic_pkg.sv | 30 +++
 rtl/demosaic_nbr_addr.sv | 46 ++++
 rtl/bayer_demosaic_param.sv | 157 +++++++++++++++
 tb/tb_bayer_demosaic_param.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demosaic_pkg.sv
// Shared types for the bilinear Bayer demosaic: CFA phases, colours, neighbour kinds, FSM states.
package demosaic_pkg;

  localparam logic [1:0] PAT_GRBG = 2'd0;
  localparam logic [1:0] PAT_RGGB = 2'd1;
  localparam logic [1:0] PAT_BGGR = 2'd2;
  localparam logic [1:0] PAT_GBRG = 2'd3;

  localparam int NUM_PLANES = 3;

  typedef enum logic [1:0] {C_R = 2'd0, C_G = 2'd1, C_B = 2'd2} colour_e;
  typedef enum logic [1:0] {K_HORIZ, K_VERT, K_CROSS, K_DIAG} nbr_kind_e;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RD, S_CAP, S_WR, S_DONE} state_e;

  function automatic colour_e site_colour(input logic row_lsb, input logic col_lsb,
                                          input logic [1:0] pattern);
    colour_e c;
    logic    g_even;
    // GRBG/GBRG carry G where row and col parity agree; RGGB/BGGR where they differ
    g_even = (pattern == PAT_GRBG) || (pattern == PAT_GBRG);
    if ((row_lsb ^ col_lsb) != g_even)
      c = C_G;
    else if (row_lsb == ((pattern == PAT_GBRG) || (pattern == PAT_BGGR)))
      c = C_R;
    else
      c = C_B;
    return c;
  endfunction

endpackage

// File: rtl/demosaic_nbr_addr.sv
// Mirrored-border neighbour address for one colour plane of the demosaic.
module demosaic_nbr_addr
  import demosaic_pkg::*;
#(
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 7
) (
  input  logic [ROW_BITS+COL_BITS-1:0] pix,
  input  logic [1:0]                   nbr_idx,
  input  nbr_kind_e                    kind,
  output logic [ROW_BITS+COL_BITS-1:0] addr
);

  logic [ROW_BITS-1:0] row, rm, rp, r_sel;
  logic [COL_BITS-1:0] col, cm, cp, c_sel;

  assign row = pix[ROW_BITS+COL_BITS-1:COL_BITS];
  assign col = pix[COL_BITS-1:0];

  // -1 reflects to 1 and W reflects to W-2, so the neighbour keeps its CFA colour
  assign rm = (row == '0) ? ROW_BITS'(1) : row - ROW_BITS'(1);
  assign rp = (row == '1) ? row - ROW_BITS'(1) : row + ROW_BITS'(1);
  assign cm = (col == '0) ? COL_BITS'(1) : col - COL_BITS'(1);
  assign cp = (col == '1) ? col - COL_BITS'(1) : col + COL_BITS'(1);

  always_comb begin
    r_sel = row;
    c_sel = col;
    case (kind)
      K_HORIZ: c_sel = nbr_idx[0] ? cp : cm;
      K_VERT:  r_sel = nbr_idx[0] ? rp : rm;
      K_CROSS: begin
        if (nbr_idx[1]) c_sel = nbr_idx[0] ? cp : cm;
        else            r_sel = nbr_idx[0] ? rp : rm;
      end
      K_DIAG: begin
        r_sel = nbr_idx[1] ? rp : rm;
        c_sel = nbr_idx[0] ? cp : cm;
      end
      default: ;
    endcase
  end

  assign addr = {r_sel, c_sel};

endmodule

// File: rtl/bayer_demosaic_param.sv
// Parametrised bilinear Bayer demosaic: loads a raw frame into R/G/B planes, then
// interpolates the two missing colours per pixel from mirrored neighbours.
module bayer_demosaic_param
  import demosaic_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 7,
  parameter int PATTERN  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_en,
  input  logic [DATA_W-1:0]            data_in,
  output logic                         wr_r,
  output logic                         wr_g,
  output logic                         wr_b,
  output logic [ROW_BITS+COL_BITS-1:0] addr_r,
  output logic [ROW_BITS+COL_BITS-1:0] addr_g,
  output logic [ROW_BITS+COL_BITS-1:0] addr_b,
  output logic [DATA_W-1:0]            wdata_r,
  output logic [DATA_W-1:0]            wdata_g,
  output logic [DATA_W-1:0]            wdata_b,
  input  logic [DATA_W-1:0]            rdata_r,
  input  logic [DATA_W-1:0]            rdata_g,
  input  logic [DATA_W-1:0]            rdata_b,
  output logic                         done
);

  localparam int              AW     = ROW_BITS + COL_BITS;
  localparam int              SW     = DATA_W + 2;
  localparam int              STAGES = 1;
  localparam logic [1:0]      PAT    = 2'(PATTERN);
  localparam logic [AW-1:0]   LAST   = '1;

  state_e                            state;
  logic [AW-1:0]                     idx;
  logic [1:0]                        cnt, last_cnt;
  logic [STAGES:0]                   vld_pipe;
  logic                              done_q;
  logic [NUM_PLANES-1:0]             wr_q, missing;
  logic [NUM_PLANES-1:0][AW-1:0]     addr_q, nbr_addr;
  logic [NUM_PLANES-1:0][DATA_W-1:0] wdata_q, rdata, avg;
  logic [NUM_PLANES-1:0][SW-1:0]     sum, total;
  colour_e                           site, horiz_c;
  logic                              g_site;

  assign site     = site_colour(idx[COL_BITS], idx[0], PAT);
  assign horiz_c  = site_colour(idx[COL_BITS], ~idx[0], PAT);
  assign g_site   = (site == C_G);
  assign last_cnt = g_site ? 2'd1 : 2'd3;
  assign rdata    = {rdata_b, rdata_g, rdata_r};

  for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
    localparam colour_e PC = colour_e'(p);
    nbr_kind_e kind;

    assign missing[p] = (site != PC);
    // at a G site the row-mate colour comes from the horizontal pair, the other from vertical
    assign kind = g_site ? ((horiz_c == PC) ? K_HORIZ : K_VERT)
                         : ((PC == C_G) ? K_CROSS : K_DIAG);

    demosaic_nbr_addr #(.COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS)) u_nbr (
      .pix     (idx),
      .nbr_idx (cnt),
      .kind    (kind),
      .addr    (nbr_addr[p])
    );

    // the last read lands in WR, so fold it in combinationally there
    assign total[p] = sum[p] + (vld_pipe[STAGES] ? SW'(rdata[p]) : '0);
    assign avg[p]   = g_site ? DATA_W'((total[p] + SW'(1)) >> 1)
                             : DATA_W'((total[p] + SW'(2)) >> 2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      sum      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], state == S_RD};
      if (state == S_WR)          sum <= '0;
      else if (vld_pipe[STAGES])  sum <= total;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
      wr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wr_q <= '0;
      case (state)
        S_IDLE, S_LOAD: begin
          if (in_en) begin
            for (int p = 0; p < NUM_PLANES; p++) begin
              if (!missing[p]) begin
                wr_q[p]    <= 1'b1;
                addr_q[p]  <= idx;
                wdata_q[p] <= data_in;
              end
            end
            idx   <= idx + AW'(1);
            state <= (state == S_LOAD && idx == LAST) ? S_RD : S_LOAD;
          end
        end
        S_RD: begin
          for (int p = 0; p < NUM_PLANES; p++)
            if (missing[p]) addr_q[p] <= nbr_addr[p];
          if (cnt == last_cnt) begin
            cnt   <= '0;
            state <= S_CAP;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_CAP: state <= S_WR;
        S_WR: begin
          for (int p = 0; p < NUM_PLANES; p++) begin
            if (missing[p]) begin
              wr_q[p]    <= 1'b1;
              addr_q[p]  <= idx;
              wdata_q[p] <= avg[p];
            end
          end
          idx   <= idx + AW'(1);
          state <= (idx == LAST) ? S_DONE : S_RD;
        end
        S_DONE: begin
          if (in_en) begin
            done_q <= 1'b0;
            idx    <= '0;
            state  <= S_LOAD;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign {wr_b, wr_g, wr_r} = wr_q;
  assign addr_r  = addr_q[0];
  assign addr_g  = addr_q[1];
  assign addr_b  = addr_q[2];
  assign wdata_r = wdata_q[0];
  assign wdata_g = wdata_q[1];
  assign wdata_b = wdata_q[2];
  assign done    = done_q;

endmodule

// File: tb/tb_bayer_demosaic_param.sv
// Directed bench: 4x4 frames on a GRBG instance and an RGGB instance, each with a plane memory model.
module tb_bayer_demosaic_param;

  logic clk = 1'b0;
  logic reset;
  logic [1:0]            in_en;
  logic [1:0][7:0]       data_in;
  logic [1:0][2:0]       wr;
  logic [1:0][2:0][3:0]  addr;
  logic [1:0][2:0][7:0]  wdata, rdata;
  logic [1:0]            done;
  logic [7:0]            mem [2][3][16];
  int fr [16];
  // colour per {pattern, row parity, col parity}: R=0 G=1 B=2
  int cfa_t [16] = '{1,0,2,1, 0,1,1,2, 2,1,1,0, 1,2,0,1};
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar u = 0; u < 2; u++) begin : g_dut
    bayer_demosaic_param #(.DATA_W(8), .COL_BITS(2), .ROW_BITS(2), .PATTERN(u)) dut (
      .clk(clk), .reset(reset), .in_en(in_en[u]), .data_in(data_in[u]),
      .wr_r(wr[u][0]), .wr_g(wr[u][1]), .wr_b(wr[u][2]),
      .addr_r(addr[u][0]), .addr_g(addr[u][1]), .addr_b(addr[u][2]),
      .wdata_r(wdata[u][0]), .wdata_g(wdata[u][1]), .wdata_b(wdata[u][2]),
      .rdata_r(rdata[u][0]), .rdata_g(rdata[u][1]), .rdata_b(rdata[u][2]),
      .done(done[u]));
  end

  always @(posedge clk)
    for (int u = 0; u < 2; u++)
      for (int p = 0; p < 3; p++) begin
        if (wr[u][p]) mem[u][p][addr[u][p]] <= wdata[u][p];
        rdata[u][p] <= mem[u][p][addr[u][p]];
      end

  function automatic int cfa(int pat, int r, int c);
    return cfa_t[pat*4 + (r%2)*2 + (c%2)];
  endfunction

  function automatic int mir(int x);
    return (x < 0) ? 1 : (x > 3) ? 2 : x;
  endfunction

  // bilinear reference: cross neighbours of the wanted colour, else the diagonals
  function automatic int model(int pat, int r, int c, int col);
    int s = 0, n = 0, rr, cc;
    int dr [8] = '{-1, 1, 0, 0, -1, -1, 1, 1};
    int dc [8] = '{ 0, 0,-1, 1, -1,  1,-1, 1};
    if (cfa(pat, r, c) == col) return fr[r*4+c];
    for (int k = 0; k < 8; k++) begin
      if (k == 4 && n != 0) break;
      rr = mir(r + dr[k]);
      cc = mir(c + dc[k]);
      if (cfa(pat, rr, cc) == col) begin
        s += fr[rr*4+cc];
        n++;
      end
    end
    return (s + n/2) / n;
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_en = '0; data_in = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic load_frame(input int u);
    for (int i = 0; i < 16; i++) begin
      in_en[u] = 1'b1; data_in[u] = 8'(fr[i]);
      @(posedge clk); #1;
    end
    in_en[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, output int cyc);
    cyc = 0;
    while (!done[u] && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_en = '0; data_in = '0;
    #2;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({wr[u], addr[u], wdata[u], done[u]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d got %h want 0", u, {wr[u], addr[u], wdata[u], done[u]});
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_grbg();
    int cyc;
    logic [2:0] exp_wr;
    do_reset();
    for (int i = 0; i < 16; i++) fr[i] = 10*i;
    for (int i = 0; i < 16; i++) begin
      in_en[0] = 1'b1; data_in[0] = 8'(fr[i]);
      @(posedge clk); #1;
      exp_wr = 3'(1 << cfa(0, i/4, i%4));
      checks++;
      if (wr[0] !== exp_wr || addr[0][cfa(0, i/4, i%4)] !== 4'(i) ||
          wdata[0][cfa(0, i/4, i%4)] !== 8'(fr[i])) begin
        errors++;
        $display("FAIL grbg_load i%0d got wr=%b addr=%h wdata=%h want wr=%b addr=%0d wdata=%0d",
                 i, wr[0], addr[0], wdata[0], exp_wr, i, fr[i]);
      end
    end
    in_en[0] = 1'b0;
    wait_done(0, cyc);
    checks++;
    if (16 + cyc !== 97) begin
      errors++;
      $display("FAIL grbg_done_cycle got %0d want 97", 16 + cyc);
    end
    checks++;
    if (mem[0][0][5] !== 8'd50 || mem[0][2][5] !== 8'd50) begin
      errors++;
      $display("FAIL grbg_rb_at_1_1 got R=%0d B=%0d want 50 50", mem[0][0][5], mem[0][2][5]);
    end
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (mem[0][p][i] !== 8'(model(0, i/4, i%4, p))) begin
          errors++;
          $display("FAIL grbg_frame p%0d i%0d got %0d want %0d", p, i, mem[0][p][i], model(0, i/4, i%4, p));
        end
      end
  endtask

  task automatic test_flat();
    int cyc;
    do_reset();
    for (int i = 0; i < 16; i++) fr[i] = 200;
    load_frame(0);
    wait_done(0, cyc);
    checks++;
    if (cyc >= 400) begin
      errors++;
      $display("FAIL flat_done timeout after %0d cycles", cyc);
    end
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (mem[0][p][i] !== 8'd200) begin
          errors++;
          $display("FAIL flat_frame p%0d i%0d got %0d want 200", p, i, mem[0][p][i]);
        end
      end
  endtask

  task automatic test_rounding();
    int cyc;
    do_reset();
    for (int i = 0; i < 16; i++) fr[i] = 0;
    fr[4] = 1; fr[6] = 1; fr[12] = 1; fr[14] = 2;
    fr[1] = 3; fr[9] = 4;
    load_frame(0);
    wait_done(0, cyc);
    checks++;
    if (mem[0][2][9] !== 8'd1) begin
      errors++;
      $display("FAIL round_avg4 got %0d want 1", mem[0][2][9]);
    end
    checks++;
    if (mem[0][0][5] !== 8'd4) begin
      errors++;
      $display("FAIL round_avg2 got %0d want 4", mem[0][0][5]);
    end
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (mem[0][p][i] !== 8'(model(0, i/4, i%4, p))) begin
          errors++;
          $display("FAIL round_frame p%0d i%0d got %0d want %0d", p, i, mem[0][p][i], model(0, i/4, i%4, p));
        end
      end
  endtask

  task automatic test_corner();
    int cyc, nb5 = 0, n4 = 0, n1 = 0, wrs = 0;
    do_reset();
    for (int i = 0; i < 16; i++) fr[i] = 7*i + 3;
    load_frame(1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (addr[1][2] === 4'd5) nb5++;
      if (addr[1][1] === 4'd4) n4++;
      else if (addr[1][1] === 4'd1) n1++;
      if (wr[1] !== 3'b000) wrs++;
    end
    checks++;
    if (nb5 != 4) begin
      errors++;
      $display("FAIL corner_b_reads got %0d reads of (1,1) want 4", nb5);
    end
    checks++;
    if (n4 != 2 || n1 != 2) begin
      errors++;
      $display("FAIL corner_g_reads got (1,0)x%0d (0,1)x%0d want 2 2", n4, n1);
    end
    checks++;
    if (wrs != 0) begin
      errors++;
      $display("FAIL corner_rd_no_wr got %0d write cycles want 0", wrs);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (wr[1] !== 3'b110 || addr[1][1] !== 4'd0 || addr[1][2] !== 4'd0 ||
        wdata[1][1] !== 8'd21 || wdata[1][2] !== 8'd38) begin
      errors++;
      $display("FAIL corner_wr got wr=%b ag=%0d ab=%0d g=%0d b=%0d want 110 0 0 21 38",
               wr[1], addr[1][1], addr[1][2], wdata[1][1], wdata[1][2]);
    end
    wait_done(1, cyc);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (mem[1][p][i] !== 8'(model(1, i/4, i%4, p))) begin
          errors++;
          $display("FAIL corner_frame p%0d i%0d got %0d want %0d", p, i, mem[1][p][i], model(1, i/4, i%4, p));
        end
      end
  endtask

  task automatic test_stall();
    int cyc;
    logic [2:0] exp_wr;
    do_reset();
    for (int i = 0; i < 16; i++) fr[i] = (13*i + 5) % 256;
    for (int i = 0; i < 16; i++) begin
      in_en[0] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (wr[0] !== 3'b000) begin
        errors++;
        $display("FAIL stall_idle i%0d got wr=%b want 000", i, wr[0]);
      end
      in_en[0] = 1'b1; data_in[0] = 8'(fr[i]);
      @(posedge clk); #1;
      exp_wr = 3'(1 << cfa(0, i/4, i%4));
      checks++;
      if (wr[0] !== exp_wr) begin
        errors++;
        $display("FAIL stall_write i%0d got wr=%b want %b", i, wr[0], exp_wr);
      end
    end
    in_en[0] = 1'b0;
    wait_done(0, cyc);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (mem[0][p][i] !== 8'(model(0, i/4, i%4, p))) begin
          errors++;
          $display("FAIL stall_frame p%0d i%0d got %0d want %0d", p, i, mem[0][p][i], model(0, i/4, i%4, p));
        end
      end
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    for (int i = 0; i < 16; i++) fr[i] = 3*i + 1;
    load_frame(0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({wr[0], addr[0], wdata[0], done[0]} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %h want 0", {wr[0], addr[0], wdata[0], done[0]});
    end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) fr[i] = (11*i + 2) % 256;
    load_frame(0);
    wait_done(0, cyc);
    checks++;
    if (16 + cyc !== 97) begin
      errors++;
      $display("FAIL reset_mid_done_cycle got %0d want 97", 16 + cyc);
    end
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (mem[0][p][i] !== 8'(model(0, i/4, i%4, p))) begin
          errors++;
          $display("FAIL reset_mid_frame p%0d i%0d got %0d want %0d", p, i, mem[0][p][i], model(0, i/4, i%4, p));
        end
      end
  endtask

  initial begin
    test_reset();
    test_grbg();
    test_flat();
    test_rounding();
    test_corner();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
